// File: rtl/i2c_role_arbiter_pkg.sv
// +----------------------------------------------------------------------------+
// | Module   : i2c_role_arbiter_pkg                                            |
// | Purpose  : Shared role and arbiter-state types for the I2C role arbiter.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

package i2c_role_arbiter_pkg;

    typedef enum logic {
        MASTER = 1'b0,
        SLAVE  = 1'b1
    } MasterSlave;

    typedef enum logic [1:0] {
        SLAVE_ACT   = 2'd0,
        MASTER_WAIT = 2'd1,
        MASTER_ACT  = 2'd2,
        DRAIN       = 2'd3
    } ArbState;

    // The master owns the bus from the grant until it has fully drained.
    function automatic MasterSlave role_of(input ArbState s);
        return ((s == MASTER_ACT) || (s == DRAIN)) ? MASTER : SLAVE;
    endfunction

endpackage

`default_nettype wire

// File: rtl/i2c_role_arbiter_if.sv
// +----------------------------------------------------------------------------+
// | Module   : i2c_role_arbiter_if                                             |
// | Purpose  : Engine, register and pad signals around the I2C role arbiter.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

interface i2c_role_arbiter_if #(
    parameter int TBUF_W = 16
) ();
    logic              SDA_sync;
    logic              SCL_sync;
    logic              ms_select;
    logic              transaction_begin;
    logic [TBUF_W-1:0] tbuf_cycles;
    logic              busy_master;
    logic              busy_slave;
    logic              set_arbitration_lost;
    logic              SDA_out_master;
    logic              SCL_out_master;
    logic              SDA_out_slave;
    logic              SCL_out_slave;
    logic [7:0]        rx_data_master;
    logic [7:0]        rx_data_slave;
    logic              ack_error_set_master;
    logic              ack_error_set_slave;
    logic              TX_read_enable_master;
    logic              TX_read_enable_slave;
    logic              RX_write_enable_master;
    logic              RX_write_enable_slave;
    logic              set_transaction_complete_master;
    logic              set_transaction_complete_slave;

    logic              master_go;
    logic              transaction_begin_clear;
    logic              active_role;
    logic              line_busy;
    logic              bus_free;
    logic              SDA_out;
    logic              SCL_out;
    logic [7:0]        rx_data;
    logic              ack_error_set;
    logic              busy;
    logic              TX_read_enable;
    logic              RX_write_enable;
    logic              set_transaction_complete;

    // slave: the arbiter's view; master: the surrounding engines/registers/pads.
    modport slave (
        input  SDA_sync, SCL_sync, ms_select, transaction_begin, tbuf_cycles,
               busy_master, busy_slave, set_arbitration_lost,
               SDA_out_master, SCL_out_master, SDA_out_slave, SCL_out_slave,
               rx_data_master, rx_data_slave,
               ack_error_set_master, ack_error_set_slave,
               TX_read_enable_master, TX_read_enable_slave,
               RX_write_enable_master, RX_write_enable_slave,
               set_transaction_complete_master, set_transaction_complete_slave,
        output master_go, transaction_begin_clear, active_role, line_busy, bus_free,
               SDA_out, SCL_out, rx_data, ack_error_set, busy,
               TX_read_enable, RX_write_enable, set_transaction_complete
    );

    modport master (
        output SDA_sync, SCL_sync, ms_select, transaction_begin, tbuf_cycles,
               busy_master, busy_slave, set_arbitration_lost,
               SDA_out_master, SCL_out_master, SDA_out_slave, SCL_out_slave,
               rx_data_master, rx_data_slave,
               ack_error_set_master, ack_error_set_slave,
               TX_read_enable_master, TX_read_enable_slave,
               RX_write_enable_master, RX_write_enable_slave,
               set_transaction_complete_master, set_transaction_complete_slave,
        input  master_go, transaction_begin_clear, active_role, line_busy, bus_free,
               SDA_out, SCL_out, rx_data, ack_error_set, busy,
               TX_read_enable, RX_write_enable, set_transaction_complete
    );
endinterface

`default_nettype wire

// File: rtl/i2c_role_arbiter_bus_monitor.sv
// +----------------------------------------------------------------------------+
// | Module   : i2c_role_arbiter_bus_monitor                                    |
// | Purpose  : START/STOP detection, line-busy flag, bus-free counter and the  |
// |            optional SCL-low timeout (I2C_ARB_SCL_TIMEOUT_EN).              |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module i2c_role_arbiter_bus_monitor #(
    parameter int TBUF_W = 16
`ifdef I2C_ARB_SCL_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 25000
`endif
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              sda_sync,
    input  logic              scl_sync,
    input  logic [TBUF_W-1:0] tbuf_cycles,
    output logic              line_busy,
    output logic              bus_free,
    output logic              scl_timeout
);

    localparam logic [TBUF_W-1:0] c_FREE_MAX = '1;

    logic              r_sda_prev;
    logic              r_scl_prev;
    logic              r_line_busy;
    logic              r_bus_free;
    logic [TBUF_W-1:0] r_free_cnt;
    logic [TBUF_W-1:0] w_free_cnt_next;
    logic              w_start;
    logic              w_stop;
    logic              w_idle;
    logic              w_timeout;

`ifdef I2C_ARB_SCL_TIMEOUT_EN
    localparam int c_TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_TO_W-1:0] r_scl_low_cnt;

    // Saturates at the limit so the timeout fires once per low period.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_scl_low_cnt <= '0;
        end else if (scl_sync) begin
            r_scl_low_cnt <= '0;
        end else if (r_scl_low_cnt != c_TO_W'(TIMEOUT_CYCLES)) begin
            r_scl_low_cnt <= r_scl_low_cnt + 1'b1;
        end
    end

    assign w_timeout = !scl_sync && (r_scl_low_cnt == c_TO_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    assign w_start = r_scl_prev && scl_sync &&  r_sda_prev && !sda_sync;
    assign w_stop  = r_scl_prev && scl_sync && !r_sda_prev &&  sda_sync;
    assign w_idle  = !r_line_busy && sda_sync && scl_sync;

    always_comb begin
        w_free_cnt_next = '0;
        if (w_idle && !w_timeout) begin
            w_free_cnt_next = (r_free_cnt == c_FREE_MAX) ? r_free_cnt : r_free_cnt + 1'b1;
        end
    end

    // bus_free is judged on the post-edge count so a zero threshold lags idle by one cycle.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_sda_prev  <= 1'b1;
            r_scl_prev  <= 1'b1;
            r_line_busy <= 1'b0;
            r_free_cnt  <= '0;
            r_bus_free  <= 1'b0;
        end else begin
            r_sda_prev <= sda_sync;
            r_scl_prev <= scl_sync;
            if (w_stop || w_timeout) begin
                r_line_busy <= 1'b0;
            end else if (w_start) begin
                r_line_busy <= 1'b1;
            end
            r_free_cnt <= w_free_cnt_next;
            r_bus_free <= w_idle && !w_timeout && (w_free_cnt_next >= tbuf_cycles);
        end
    end

    assign line_busy   = r_line_busy;
    assign bus_free    = r_bus_free;
    assign scl_timeout = w_timeout;

endmodule

`default_nettype wire

// File: rtl/i2c_role_arbiter.sv
// +----------------------------------------------------------------------------+
// | Module   : i2c_role_arbiter                                                |
// | Purpose  : Grants the shared I2C bus to the master or slave engine and     |
// |            muxes pads/status; optional SCL timeout: I2C_ARB_SCL_TIMEOUT_EN.|
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module i2c_role_arbiter
    import i2c_role_arbiter_pkg::*;
#(
    parameter int TBUF_W = 16
`ifdef I2C_ARB_SCL_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 25000
`endif
) (
    input  logic                clk,
    input  logic                n_rst,
    i2c_role_arbiter_if.slave   bus
);

    ArbState    r_state;
    ArbState    w_next_state;
    MasterSlave r_active_role;
    logic       r_master_go;
    logic       r_busy_low_seen;
    logic       r_pads_en;
    logic       w_go;
    logic       w_master_sel;
    logic       w_line_busy;
    logic       w_bus_free;
    logic       w_scl_timeout;

    i2c_role_arbiter_bus_monitor #(
        .TBUF_W         (TBUF_W)
`ifdef I2C_ARB_SCL_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
`endif
    ) u_bus_monitor (
        .clk         (clk),
        .n_rst       (n_rst),
        .sda_sync    (bus.SDA_sync),
        .scl_sync    (bus.SCL_sync),
        .tbuf_cycles (bus.tbuf_cycles),
        .line_busy   (w_line_busy),
        .bus_free    (w_bus_free),
        .scl_timeout (w_scl_timeout)
    );

    always_comb begin
        w_next_state = r_state;
        w_go         = 1'b0;
        case (r_state)
            SLAVE_ACT: begin
                if ((bus.ms_select == MASTER) && bus.transaction_begin) begin
                    w_next_state = MASTER_WAIT;
                end
            end
            MASTER_WAIT: begin
                if (bus.ms_select == SLAVE) begin
                    w_next_state = SLAVE_ACT;
                end else if (w_bus_free && !bus.busy_slave) begin
                    w_next_state = MASTER_ACT;
                    w_go         = 1'b1;
                end
            end
            MASTER_ACT: begin
                // r_master_go marks the first cycle, which the busy-low check skips.
                if (bus.set_arbitration_lost || w_scl_timeout) begin
                    w_next_state = DRAIN;
                end else if (bus.set_transaction_complete_master ||
                             (!r_master_go && !bus.busy_master && r_busy_low_seen)) begin
                    w_next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (!bus.busy_master) begin
                    w_next_state = SLAVE_ACT;
                end
            end
            default: w_next_state = SLAVE_ACT;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state         <= SLAVE_ACT;
            r_active_role   <= SLAVE;
            r_master_go     <= 1'b0;
            r_busy_low_seen <= 1'b0;
            r_pads_en       <= 1'b0;
        end else begin
            r_state         <= w_next_state;
            r_active_role   <= role_of(w_next_state);
            r_master_go     <= w_go;
            r_busy_low_seen <= (r_state == MASTER_ACT) && !r_master_go && !bus.busy_master;
            r_pads_en       <= 1'b1;
        end
    end

    assign w_master_sel = (r_active_role == MASTER);

    // Pads stay released through reset and its first clock, and while draining.
    always_comb begin
        bus.SDA_out = 1'b1;
        bus.SCL_out = 1'b1;
        if (r_pads_en && (r_state != DRAIN)) begin
            bus.SDA_out = w_master_sel ? bus.SDA_out_master : bus.SDA_out_slave;
            bus.SCL_out = w_master_sel ? bus.SCL_out_master : bus.SCL_out_slave;
        end
    end

    assign bus.master_go                = r_master_go;
    assign bus.transaction_begin_clear  = r_master_go;
    assign bus.active_role              = r_active_role;
    assign bus.line_busy                = w_line_busy;
    assign bus.bus_free                 = w_bus_free;
    assign bus.busy                     = bus.busy_master | bus.busy_slave | (r_state != SLAVE_ACT);
    assign bus.rx_data                  = w_master_sel ? bus.rx_data_master : bus.rx_data_slave;
    assign bus.ack_error_set            = w_master_sel ? bus.ack_error_set_master
                                                       : bus.ack_error_set_slave;
    assign bus.TX_read_enable           = w_master_sel ? bus.TX_read_enable_master
                                                       : bus.TX_read_enable_slave;
    assign bus.RX_write_enable          = w_master_sel ? bus.RX_write_enable_master
                                                       : bus.RX_write_enable_slave;
    assign bus.set_transaction_complete = w_master_sel ? bus.set_transaction_complete_master
                                                       : bus.set_transaction_complete_slave;

endmodule

`default_nettype wire

// File: tb/tb_i2c_role_arbiter.sv
// +----------------------------------------------------------------------------+
// | Module   : tb_i2c_role_arbiter                                             |
// | Purpose  : Directed self-checking bench for i2c_role_arbiter.              |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_i2c_role_arbiter;
    import i2c_role_arbiter_pkg::*;

    logic clk;
    logic n_rst;
    int   n_cmp;
    int   n_bad;

    i2c_role_arbiter_if #(.TBUF_W(16)) bus ();

    i2c_role_arbiter #(.TBUF_W(16)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        n_rst = 1'b0;
        bus.SDA_sync = 1'b1;
        bus.SCL_sync = 1'b1;
        bus.ms_select = SLAVE;
        bus.transaction_begin = 1'b0;
        bus.tbuf_cycles = 16'd10;
        bus.busy_master = 1'b0;
        bus.busy_slave = 1'b0;
        bus.set_arbitration_lost = 1'b0;
        bus.SDA_out_master = 1'b1;
        bus.SCL_out_master = 1'b1;
        bus.SDA_out_slave = 1'b0;
        bus.SCL_out_slave = 1'b0;
        bus.rx_data_master = 8'hA5;
        bus.rx_data_slave = 8'h5A;
        bus.ack_error_set_master = 1'b1;
        bus.ack_error_set_slave = 1'b0;
        bus.TX_read_enable_master = 1'b0;
        bus.TX_read_enable_slave = 1'b1;
        bus.RX_write_enable_master = 1'b1;
        bus.RX_write_enable_slave = 1'b0;
        bus.set_transaction_complete_master = 1'b0;
        bus.set_transaction_complete_slave = 1'b0;

        // Reset values (slave engine pulling low must not reach the pads)
        tick(2);
        chk("rst_role", bus.active_role, SLAVE);
        chk("rst_line_busy", bus.line_busy, 0);
        chk("rst_bus_free", bus.bus_free, 0);
        chk("rst_go", bus.master_go, 0);
        chk("rst_clear", bus.transaction_begin_clear, 0);
        chk("rst_sda", bus.SDA_out, 1);
        chk("rst_scl", bus.SCL_out, 1);
        chk("rst_busy", bus.busy, 0);

        n_rst = 1'b1;
        tick(1);
        chk("slv_sda", bus.SDA_out, 0);
        chk("slv_scl", bus.SCL_out, 0);
        chk("slv_rx", bus.rx_data, 8'h5A);
        chk("slv_ack", bus.ack_error_set, 0);
        chk("slv_tx", bus.TX_read_enable, 1);
        chk("slv_rxwe", bus.RX_write_enable, 0);
        bus.SDA_out_slave = 1'b1;
        bus.SCL_out_slave = 1'b1;

        // bus_free after 10 idle cycles
        tick(8);
        chk("free_at9", bus.bus_free, 0);
        tick(1);
        chk("free_at10", bus.bus_free, 1);

        // Master request on a free bus
        bus.ms_select = MASTER;
        bus.transaction_begin = 1'b1;
        tick(1);
        chk("wait_go", bus.master_go, 0);
        chk("wait_busy", bus.busy, 1);
        chk("wait_role", bus.active_role, SLAVE);
        tick(1);
        chk("grant_go", bus.master_go, 1);
        chk("grant_clear", bus.transaction_begin_clear, 1);
        chk("grant_role", bus.active_role, MASTER);
        bus.transaction_begin = 1'b0;
        bus.busy_master = 1'b1;
        bus.SDA_out_master = 1'b0;
        bus.SCL_out_master = 1'b1;
        bus.SDA_out_slave = 1'b0;
        bus.SCL_out_slave = 1'b0;
        #1;
        chk("act_sda", bus.SDA_out, 0);
        chk("act_scl", bus.SCL_out, 1);
        chk("act_rx", bus.rx_data, 8'hA5);
        chk("act_ack", bus.ack_error_set, 1);
        chk("act_tx", bus.TX_read_enable, 0);
        tick(1);
        chk("go_once", bus.master_go, 0);
        chk("clear_once", bus.transaction_begin_clear, 0);
        bus.set_transaction_complete_master = 1'b1;
        #1;
        chk("act_stc", bus.set_transaction_complete, 1);
        tick(1);
        bus.set_transaction_complete_master = 1'b0;
        chk("tc_drain_sda", bus.SDA_out, 1);
        chk("tc_drain_scl", bus.SCL_out, 1);
        chk("tc_drain_role", bus.active_role, MASTER);
        chk("tc_drain_busy", bus.busy, 1);
        bus.busy_master = 1'b0;
        tick(1);
        chk("tc_idle_role", bus.active_role, SLAVE);
        chk("tc_idle_busy", bus.busy, 0);
        chk("tc_idle_sda", bus.SDA_out, 0);
        bus.SDA_out_slave = 1'b1;
        bus.SCL_out_slave = 1'b1;
        bus.ms_select = SLAVE;

        // START holds the request in MASTER_WAIT until STOP + 10 idle cycles
        bus.SDA_sync = 1'b0;
        tick(1);
        chk("start_line_busy", bus.line_busy, 1);
        chk("start_bus_free", bus.bus_free, 0);
        bus.SCL_sync = 1'b0;
        bus.ms_select = MASTER;
        bus.transaction_begin = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("hold_go", bus.master_go, 0);
        end
        chk("hold_busy", bus.busy, 1);
        bus.SCL_sync = 1'b1;
        tick(1);
        bus.SDA_sync = 1'b1;
        tick(1);
        chk("stop_line_busy", bus.line_busy, 0);
        tick(9);
        chk("stop_free9", bus.bus_free, 0);
        chk("stop_go9", bus.master_go, 0);
        tick(1);
        chk("stop_free10", bus.bus_free, 1);
        chk("stop_go10", bus.master_go, 0);
        tick(1);
        chk("stop_go", bus.master_go, 1);
        chk("stop_clear", bus.transaction_begin_clear, 1);

        // Arbitration lost forces DRAIN, then back to the slave
        bus.transaction_begin = 1'b0;
        bus.busy_master = 1'b1;
        bus.SDA_out_master = 1'b0;
        bus.SCL_out_master = 1'b0;
        bus.SDA_out_slave = 1'b0;
        bus.SCL_out_slave = 1'b1;
        #1;
        chk("al_pass_sda", bus.SDA_out, 0);
        chk("al_pass_scl", bus.SCL_out, 0);
        tick(1);
        bus.set_arbitration_lost = 1'b1;
        tick(1);
        bus.set_arbitration_lost = 1'b0;
        chk("al_sda", bus.SDA_out, 1);
        chk("al_scl", bus.SCL_out, 1);
        chk("al_role", bus.active_role, MASTER);
        tick(1);
        chk("al_hold_sda", bus.SDA_out, 1);
        bus.busy_master = 1'b0;
        tick(1);
        chk("al_slv_sda", bus.SDA_out, 0);
        chk("al_slv_scl", bus.SCL_out, 1);
        chk("al_slv_role", bus.active_role, SLAVE);

        // ms_select back to SLAVE while waiting cancels the request
        bus.busy_slave = 1'b1;
        bus.ms_select = MASTER;
        bus.transaction_begin = 1'b1;
        tick(2);
        chk("cancel_wait_go", bus.master_go, 0);
        chk("cancel_wait_busy", bus.busy, 1);
        bus.ms_select = SLAVE;
        bus.busy_slave = 1'b0;
        tick(1);
        chk("cancel_go", bus.master_go, 0);
        chk("cancel_clear", bus.transaction_begin_clear, 0);
        chk("cancel_busy", bus.busy, 0);
        chk("cancel_role", bus.active_role, SLAVE);
        bus.transaction_begin = 1'b0;

        // busy_master low for two cycles after the first ends the transaction
        bus.ms_select = MASTER;
        bus.transaction_begin = 1'b1;
        bus.busy_master = 1'b0;
        bus.SDA_out_master = 1'b0;
        bus.SCL_out_master = 1'b0;
        tick(2);
        chk("bl_go", bus.master_go, 1);
        bus.transaction_begin = 1'b0;
        tick(1);
        chk("bl_a1_sda", bus.SDA_out, 0);
        tick(1);
        chk("bl_a2_sda", bus.SDA_out, 0);
        tick(1);
        chk("bl_drain_sda", bus.SDA_out, 1);
        chk("bl_drain_role", bus.active_role, MASTER);
        tick(1);
        chk("bl_role", bus.active_role, SLAVE);

        // Asynchronous reset in the middle of a master transaction
        bus.transaction_begin = 1'b1;
        bus.busy_master = 1'b1;
        tick(2);
        chk("rr_go", bus.master_go, 1);
        bus.transaction_begin = 1'b0;
        bus.SDA_out_slave = 1'b0;
        bus.SCL_out_slave = 1'b0;
        #1;
        chk("rr_pass_sda", bus.SDA_out, 0);
        #2;
        n_rst = 1'b0;
        #1;
        chk("rr_sda", bus.SDA_out, 1);
        chk("rr_scl", bus.SCL_out, 1);
        chk("rr_role", bus.active_role, SLAVE);
        chk("rr_go_clr", bus.master_go, 0);
        tick(1);
        n_rst = 1'b1;
        bus.ms_select = SLAVE;
        bus.busy_master = 1'b0;
        bus.SDA_out_slave = 1'b1;
        bus.SCL_out_slave = 1'b1;
        tick(1);
        chk("rr_after_role", bus.active_role, SLAVE);
        chk("rr_after_line", bus.line_busy, 0);
        chk("rr_after_free", bus.bus_free, 0);
        chk("rr_after_busy", bus.busy, 0);

        // Zero threshold: bus_free follows idle one cycle late
        bus.tbuf_cycles = 16'd0;
        tick(1);
        chk("t0_free", bus.bus_free, 1);
        bus.SDA_sync = 1'b0;
        tick(1);
        chk("t0_start_free", bus.bus_free, 0);
        chk("t0_start_line", bus.line_busy, 1);
        bus.SDA_sync = 1'b1;
        tick(1);
        chk("t0_stop_free", bus.bus_free, 0);
        chk("t0_stop_line", bus.line_busy, 0);
        tick(1);
        chk("t0_free_again", bus.bus_free, 1);

`ifdef I2C_ARB_SCL_TIMEOUT_EN
        // SCL stuck low ends the line-busy period and drains the master
        bus.ms_select = MASTER;
        bus.transaction_begin = 1'b1;
        bus.busy_master = 1'b1;
        bus.SDA_out_master = 1'b0;
        tick(2);
        chk("to_go", bus.master_go, 1);
        bus.transaction_begin = 1'b0;
        bus.SDA_sync = 1'b0;
        tick(1);
        bus.SCL_sync = 1'b0;
        tick(24999);
        chk("to_line_before", bus.line_busy, 1);
        chk("to_sda_before", bus.SDA_out, 0);
        tick(1);
        chk("to_line_after", bus.line_busy, 0);
        chk("to_sda_drain", bus.SDA_out, 1);
        chk("to_role_drain", bus.active_role, MASTER);
        bus.busy_master = 1'b0;
        bus.ms_select = SLAVE;
        tick(1);
        chk("to_role_slave", bus.active_role, SLAVE);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
